difftest_commit_unit: RTL

- Parametrised commit/trap tracker for a multi-issue core, sitting between the core's retire stage and the Difftest DPI modules (InstrCommit per lane, TrapEvent).
- Registers up to LANES retiring instructions per cycle and keeps the cycle and instruction counters.
- Detects the trap instruction with a per-lane priority rule, forwards a0 inside the retire group for the trap code and putch character, and freezes the core view after trap.
- Successor to the single-lane negedge commit logic; adds lanes, in-group forwarding, an explicit halt FSM and per-lane putch/skip.

---
 rtl/difftest_pkg.sv | 15 +
 rtl/difftest_a0_fwd.sv | 29 ++
 rtl/difftest_commit_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/difftest_pkg.sv
// Shared types and constants for the Difftest commit/trap tracker.
package difftest_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [6:0] TRAP_OPCODE_DEFAULT  = 7'h6b;
  localparam logic [6:0] PUTCH_OPCODE_DEFAULT = 7'h7b;
  localparam int         DT_WDEST_W           = 8;
  localparam logic [4:0] A0_REG               = 5'd10;

endpackage

// File: rtl/difftest_a0_fwd.sv
// In-group a0 forwarding: each lane sees x10 as written by the youngest older effective lane.
module difftest_a0_fwd
  import difftest_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 64
) (
  input  logic [LANES-1:0]      eff,
  input  logic [LANES-1:0]      wen,
  input  logic [LANES*5-1:0]    wdest,
  input  logic [LANES*XLEN-1:0] wdata,
  input  logic [XLEN-1:0]       a0_value,
  output logic [LANES*XLEN-1:0] fa0
);

  always_comb begin
    fa0 = '0;
    for (int i = 0; i < LANES; i++) begin
      fa0[i*XLEN +: XLEN] = a0_value;
      // ascending scan so the highest older writer wins
      for (int j = 0; j < i; j++) begin
        if (eff[j] && wen[j] && (wdest[j*5 +: 5] == A0_REG)) begin
          fa0[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/difftest_commit_unit.sv
// Multi-lane commit/trap tracker feeding Difftest InstrCommit and TrapEvent.
module difftest_commit_unit
  import difftest_pkg::*;
#(
  parameter int          LANES        = 2,
  parameter int          XLEN         = 64,
  parameter logic [63:0] PC_START     = 64'h8000_0000,
  parameter logic [6:0]  TRAP_OPCODE  = TRAP_OPCODE_DEFAULT,
  parameter logic [6:0]  PUTCH_OPCODE = PUTCH_OPCODE_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*XLEN-1:0]      in_pc,
  input  logic [LANES*32-1:0]        in_inst,
  input  logic [LANES-1:0]           in_wen,
  input  logic [LANES*5-1:0]         in_wdest,
  input  logic [LANES*XLEN-1:0]      in_wdata,
  input  logic [XLEN-1:0]            a0_value,
  output logic [LANES-1:0]           cmt_valid,
  output logic [LANES*XLEN-1:0]      cmt_pc,
  output logic [LANES*32-1:0]        cmt_inst,
  output logic [LANES-1:0]           cmt_skip,
  output logic [LANES-1:0]           cmt_wen,
  output logic [LANES*DT_WDEST_W-1:0] cmt_wdest,
  output logic [LANES*XLEN-1:0]      cmt_wdata,
  output logic [LANES-1:0]           uart_valid,
  output logic [LANES*8-1:0]         uart_ch,
  output logic                       trap_valid,
  output logic [7:0]                 trap_code,
  output logic [XLEN-1:0]            trap_pc,
  output logic [63:0]                cycle_cnt,
  output logic [63:0]                instr_cnt,
  output logic                       halted
);

  state_e state_q, state_d;
  logic run;
  logic [LANES-1:0] raw, trap_l, putch_l, eff;
  logic trap_any;
  logic [63:0] eff_pop;
  logic [LANES*XLEN-1:0] fa0;
  logic [7:0] trap_code_sel;
  logic [XLEN-1:0] trap_pc_sel;

  logic [LANES-1:0] cmt_valid_q, cmt_valid_d, cmt_skip_q, cmt_skip_d;
  logic [LANES-1:0] cmt_wen_q, cmt_wen_d, uart_valid_q, uart_valid_d;
  logic [LANES*XLEN-1:0] cmt_pc_q, cmt_pc_d, cmt_wdata_q, cmt_wdata_d;
  logic [LANES*32-1:0] cmt_inst_q, cmt_inst_d;
  logic [LANES*DT_WDEST_W-1:0] cmt_wdest_q, cmt_wdest_d;
  logic [LANES*8-1:0] uart_ch_q, uart_ch_d;
  logic trap_valid_q, trap_valid_d;
  logic [7:0] trap_code_q, trap_code_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [63:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (trap_any) state_d = ST_TRAP;
      ST_TRAP: state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run    = (state_q == ST_RUN);
    halted = (state_q == ST_HALT);
  end

  // Lane qualification; the oldest trap lane blocks every younger lane.
  always_comb begin
    raw      = '0;
    trap_l   = '0;
    putch_l  = '0;
    eff      = '0;
    trap_any = 1'b0;
    eff_pop  = '0;
    for (int i = 0; i < LANES; i++) begin
      raw[i]     = in_valid[i] &
                   ~((in_pc[i*XLEN +: XLEN] == PC_START[XLEN-1:0]) && (in_inst[i*32 +: 32] == 32'd0));
      trap_l[i]  = raw[i] & (in_inst[i*32 +: 7] == TRAP_OPCODE);
      putch_l[i] = (in_inst[i*32 +: 7] == PUTCH_OPCODE);
      eff[i]     = raw[i] & ~trap_any & run;
      trap_any   = trap_any | trap_l[i];
      eff_pop    = eff_pop + 64'(eff[i]);
    end
  end

  difftest_a0_fwd #(.LANES(LANES), .XLEN(XLEN)) u_a0_fwd (
    .eff      (eff),
    .wen      (in_wen),
    .wdest    (in_wdest),
    .wdata    (in_wdata),
    .a0_value (a0_value),
    .fa0      (fa0)
  );

  always_comb begin
    trap_code_sel = '0;
    trap_pc_sel   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (trap_l[i]) begin
        trap_code_sel = fa0[i*XLEN +: 8];
        trap_pc_sel   = in_pc[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    cmt_valid_d  = eff;
    cmt_skip_d   = eff & putch_l;
    uart_valid_d = eff & putch_l;
    cmt_wen_d    = '0;
    cmt_pc_d     = run ? in_pc : cmt_pc_q;
    cmt_inst_d   = run ? in_inst : cmt_inst_q;
    cmt_wdata_d  = run ? in_wdata : cmt_wdata_q;
    cmt_wdest_d  = cmt_wdest_q;
    uart_ch_d    = uart_ch_q;
    for (int i = 0; i < LANES; i++) begin
      cmt_wen_d[i] = eff[i] & in_wen[i] & (in_wdest[i*5 +: 5] != 5'd0);
      if (run) begin
        cmt_wdest_d[i*DT_WDEST_W +: DT_WDEST_W] = {{(DT_WDEST_W-5){1'b0}}, in_wdest[i*5 +: 5]};
        uart_ch_d[i*8 +: 8] = fa0[i*XLEN +: 8];
      end
    end
    cycle_cnt_d  = run ? cycle_cnt_q + 64'd1 : cycle_cnt_q;
    instr_cnt_d  = run ? instr_cnt_q + eff_pop : instr_cnt_q;
    trap_valid_d = trap_valid_q | (run & trap_any);
    trap_code_d  = (run && trap_any) ? trap_code_sel : trap_code_q;
    trap_pc_d    = (run && trap_any) ? trap_pc_sel : trap_pc_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmt_valid_q  <= '0;
      cmt_skip_q   <= '0;
      cmt_wen_q    <= '0;
      uart_valid_q <= '0;
      cmt_pc_q     <= '0;
      cmt_inst_q   <= '0;
      cmt_wdata_q  <= '0;
      cmt_wdest_q  <= '0;
      uart_ch_q    <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      cmt_valid_q  <= cmt_valid_d;
      cmt_skip_q   <= cmt_skip_d;
      cmt_wen_q    <= cmt_wen_d;
      uart_valid_q <= uart_valid_d;
      cmt_pc_q     <= cmt_pc_d;
      cmt_inst_q   <= cmt_inst_d;
      cmt_wdata_q  <= cmt_wdata_d;
      cmt_wdest_q  <= cmt_wdest_d;
      uart_ch_q    <= uart_ch_d;
      trap_valid_q <= trap_valid_d;
      trap_code_q  <= trap_code_d;
      trap_pc_q    <= trap_pc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign cmt_valid  = cmt_valid_q;
  assign cmt_pc     = cmt_pc_q;
  assign cmt_inst   = cmt_inst_q;
  assign cmt_skip   = cmt_skip_q;
  assign cmt_wen    = cmt_wen_q;
  assign cmt_wdest  = cmt_wdest_q;
  assign cmt_wdata  = cmt_wdata_q;
  assign uart_valid = uart_valid_q;
  assign uart_ch    = uart_ch_q;
  assign trap_valid = trap_valid_q;
  assign trap_code  = trap_code_q;
  assign trap_pc    = trap_pc_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;

endmodule
